ao486_irq_ctrl: RTL and testbench
=================================

Name: ao486_irq_ctrl

Overview:
Interrupt controller directly upstream of ao486_cpu_wb_wrapper, driving its interrupt_do / interrupt_vector / interrupt_done handshake.
- Collects up to 16 device interrupt lines and latches them into a pending register (IRR).
- Arbitrates with fixed, fully-nested priority and presents one vector at a time to the CPU.
- Tracks in-service lines (ISR) until software issues EOI.
- Software controls it through a small 32-bit Wishbone slave on the CPU IO bus.

Parameters:
NIRQ, 16, number of interrupt lines (legal range 1..16)
VEC_BASE_LO, 8'h08, vector for irq 0; irq n<8 yields VEC_BASE_LO+n
VEC_BASE_HI, 8'h70, vector for irq 8; irq n>=8 yields VEC_BASE_HI+(n-8)

Ports:
cpu_clk_i  in  1  clock
cpu_rst_n_i  in  1  reset, asynchronous, active-low
irq_i  in  NIRQ  device interrupt lines, asynchronous
interrupt_do  out  1  request to CPU
interrupt_vector  out  8  vector, valid while interrupt_do=1
interrupt_done  in  1  one-cycle CPU acknowledge
wbs_adr_i  in  4  byte address; bits [3:2] select register
wbs_dat_i  in  32  write data
wbs_sel_i  in  4  byte enables
wbs_we_i  in  1  write enable
wbs_cyc_i  in  1  cycle
wbs_stb_i  in  1  strobe
wbs_dat_o  out  32  read data
wbs_ack_o  out  1  acknowledge
wbs_err_o  out  1  tied 0
wbs_rty_o  out  1  tied 0

Behaviour:
- Reset (async assert, sync release): interrupt_do=0, interrupt_vector=0, wbs_ack_o=0, wbs_dat_o=0, IRR=0, ISR=0, IMR=all ones (all masked), synchronizers=0, FSM=IDLE.
- Input path:
  - Each irq_i bit passes a 2-flop synchronizer.
  - A rising edge on the synchronized bit sets IRR[n].
  - Edge latency: irq_i rise to IRR set is 3 cycles.
- Eligibility:
  - cand = IRR & ~IMR.
  - Winner = lowest index in cand.
  - The winner is eligible only if its index is strictly below the lowest set ISR bit (ISR=0 means always eligible).
- FSM IDLE:
  - If an eligible winner exists, latch its index w, drive interrupt_vector per the parameter rule, set interrupt_do=1 (registered, one cycle after eligibility), go to REQ.
- FSM REQ:
  - interrupt_do and interrupt_vector are held stable.
  - No preemption while in REQ: a higher-priority arrival, IMR writes and EOI writes do not change the presented vector.
  - On interrupt_done=1: clear IRR[w], set ISR[w], interrupt_do=0 in the next cycle, go to WAIT.
- FSM WAIT: one cycle; lets IRR/ISR settle before re-arbitration, then go to IDLE. Back-to-back requests are therefore spaced by at least 2 idle cycles.
- interrupt_done while IDLE/WAIT: ignored.
- Same-cycle conflicts:
  - Edge on line w in the same cycle as done for w: set wins; IRR[w] stays 1.
  - Same-cycle set and clear on ISR (done vs EOI on same bit): set wins.
- Wishbone:
  - Valid access = cyc&stb&~ack.
  - wbs_ack_o pulses exactly one cycle later.
  - Reads return zero-extended data, registered with the ack.
  - Writes honour wbs_sel_i per byte; only bits [NIRQ-1:0] are implemented.
- Register map:
  - 0x0 IMR: RW; 1 = masked.
  - 0x4 IRR: RO; writes ignored.
  - 0x8 ISR: RO.
  - 0xC EOI: WO; ISR &= ~wdata; reads return 0.
- Masking an already-pending line keeps IRR set; unmasking later delivers it.
- Reset mid-REQ: interrupt_do drops asynchronously and all state returns to reset values.

Optional Feature:
AO486_IRQ_LEVEL_EN:
- Defined: IRR[n] is continuously the synchronized level of irq_i[n], with no edge latch. done does not clear IRR; the device must deassert. Arbitration is unchanged.
- Undefined: edge-triggered latching as described in Behaviour.

Test Plan:
- Reset, write IMR=0xFFFE, pulse irq_i[0] -> interrupt_do=1 with vector 0x08; pulse done -> do=0 next cycle, ISR=0x0001, IRR=0x0000.
- IMR=0, irq 3 and 9 rise in the same cycle -> vector 0x0B first. With ISR[3] set, irq 9 is withheld; EOI write 0x0008 -> vector 0x71 presented.
- Nesting: ISR[5] in service, irq 2 rises -> vector 0x0A presented; irq 7 rises -> not presented until EOI 0x0004 and 0x0020 both written.
- Edge on irq 4 in the same cycle as done for irq 4 -> IRR reads 0x0010 afterwards, and irq 4 is re-requested after EOI.
- IMR=0xFFFF, irq 1 rises -> no request, IRR reads 0x0002; write IMR=0xFFFD -> vector 0x09. Assert cpu_rst_n_i low mid-REQ -> do=0 immediately, IMR reads 0xFFFF.
- With AO486_IRQ_LEVEL_EN: hold irq 6 high through done and EOI -> re-requested with vector 0x0E; drop irq 6 -> IRR[6]=0 after 2 cycles.

Source files
------------

// File: rtl/ao486_irq_ctrl.sv
// ao486_irq_ctrl: fixed-priority, fully-nested interrupt controller for the ao486 CPU.
// Latches device interrupt lines into IRR and presents one vector at a time to the CPU
// through interrupt_do / interrupt_vector / interrupt_done. It tracks in-service lines in
// ISR until software writes EOI, and exposes IMR/IRR/ISR/EOI through a Wishbone slave.
// Build option: define AO486_IRQ_LEVEL_EN to make IRR follow the synchronized irq_i level
// instead of latching rising edges.
module ao486_irq_ctrl #(
  parameter int unsigned NIRQ        = 16,
  parameter logic [7:0]  VEC_BASE_LO = 8'h08,
  parameter logic [7:0]  VEC_BASE_HI = 8'h70
) (
  input  logic            cpu_clk_i,
  input  logic            cpu_rst_n_i,
  input  logic [NIRQ-1:0] irq_i,
  output logic            interrupt_do,
  output logic [7:0]      interrupt_vector,
  input  logic            interrupt_done,
  input  logic [3:0]      wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic            wbs_we_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  output logic [31:0]     wbs_dat_o,
  output logic            wbs_ack_o,
  output logic            wbs_err_o,
  output logic            wbs_rty_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e          r_state;
  logic [3:0]      r_win;
  logic [NIRQ-1:0] r_sync1, r_sync2;
  logic [NIRQ-1:0] r_imr, r_isr;
  logic [NIRQ-1:0] w_irr, w_cand, w_win_oh, w_done_set, w_eoi_clr, w_imr_next;
  logic [3:0]      w_win;
  logic [4:0]      w_isr_lo;
  logic            w_win_any, w_eligible;
  logic [7:0]      w_vec;
  logic [31:0]     w_wmask, w_rdata;
  logic            w_valid, w_wr;
  logic            w_unused;

  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;

  assign w_valid = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign w_wr    = w_valid & wbs_we_i;
  assign w_wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign w_unused = ^{wbs_adr_i[1:0], wbs_dat_i, w_wmask};

  // Two-flop synchronizer on every interrupt line
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_n_i) begin
    if (!cpu_rst_n_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_i;
      r_sync2 <= r_sync1;
    end
  end

  // Decoded register-side effects of the current Wishbone access and CPU acknowledge
  always_comb begin
    w_imr_next = (r_imr & ~w_wmask[NIRQ-1:0]) | (wbs_dat_i[NIRQ-1:0] & w_wmask[NIRQ-1:0]);
    w_eoi_clr  = '0;
    if (w_wr && wbs_adr_i[3:2] == 2'd3) w_eoi_clr = wbs_dat_i[NIRQ-1:0] & w_wmask[NIRQ-1:0];
    w_win_oh = '0;
    for (int i = 0; i < int'(NIRQ); i++) w_win_oh[i] = (r_win == 4'(i));
    w_done_set = (r_state == StReq && interrupt_done) ? w_win_oh : '0;
  end

`ifdef AO486_IRQ_LEVEL_EN
  // Level mode: IRR is the synchronized line itself; the device must deassert
  assign w_irr = r_sync2;
`else
  logic [NIRQ-1:0] r_sync_prev, r_irr;

  // Edge mode: latch synchronized rising edges; a new edge beats the acknowledge clear
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_n_i) begin
    if (!cpu_rst_n_i) begin
      r_sync_prev <= '0;
      r_irr       <= '0;
    end else begin
      r_sync_prev <= r_sync2;
      r_irr       <= (r_irr & ~w_done_set) | (r_sync2 & ~r_sync_prev);
    end
  end

  assign w_irr = r_irr;
`endif

  // Lowest-index unmasked pending line wins; it must outrank every in-service line
  always_comb begin
    w_cand    = w_irr & ~r_imr;
    w_win     = '0;
    w_win_any = 1'b0;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_win_any = 1'b1;
        w_win     = 4'(i);
      end
    end
    w_isr_lo = 5'd16;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (r_isr[i]) w_isr_lo = 5'(i);
    end
    w_eligible = w_win_any && ({1'b0, w_win} < w_isr_lo);
    if (w_win < 4'd8) w_vec = VEC_BASE_LO + {4'b0, w_win};
    else              w_vec = VEC_BASE_HI + {4'b0, w_win} - 8'd8;
  end

  // Request FSM; vector and request are held unchanged while in REQ
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_n_i) begin
    if (!cpu_rst_n_i) begin
      r_state          <= StIdle;
      r_win            <= '0;
      interrupt_do     <= 1'b0;
      interrupt_vector <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_eligible) begin
            r_win            <= w_win;
            interrupt_vector <= w_vec;
            interrupt_do     <= 1'b1;
            r_state          <= StReq;
          end
        end
        StReq: begin
          if (interrupt_done) begin
            interrupt_do <= 1'b0;
            r_state      <= StWait;
          end
        end
        StWait:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // In-service tracking; acknowledge set wins over a same-cycle EOI clear
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_n_i) begin
    if (!cpu_rst_n_i) r_isr <= '0;
    else              r_isr <= (r_isr & ~w_eoi_clr) | w_done_set;
  end

  // Read-data mux, zero-extended to the bus width
  always_comb begin
    unique case (wbs_adr_i[3:2])
      2'd0:    w_rdata = 32'(r_imr);
      2'd1:    w_rdata = 32'(w_irr);
      2'd2:    w_rdata = 32'(r_isr);
      default: w_rdata = '0;
    endcase
  end

  // Wishbone slave: single-cycle ack, registered read data, byte-enabled IMR writes
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_n_i) begin
    if (!cpu_rst_n_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      r_imr     <= '1;
    end else begin
      wbs_ack_o <= w_valid;
      wbs_dat_o <= (w_valid && !wbs_we_i) ? w_rdata : '0;
      if (w_wr && wbs_adr_i[3:2] == 2'd0) r_imr <= w_imr_next;
    end
  end

endmodule

// File: tb/tb_ao486_irq_ctrl.sv
// Directed self-checking bench for ao486_irq_ctrl (default NIRQ=16, vectors 0x08/0x70).
module tb_ao486_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] irq = '0;
  logic        ido, idone = 1'b0;
  logic [7:0]  ivec;
  logic [3:0]  adr = '0;
  logic [31:0] wdat = '0, rdat;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic        ack, err, rty;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  ao486_irq_ctrl dut (
    .cpu_clk_i        (clk),
    .cpu_rst_n_i      (rst_n),
    .irq_i            (irq),
    .interrupt_do     (ido),
    .interrupt_vector (ivec),
    .interrupt_done   (idone),
    .wbs_adr_i        (adr),
    .wbs_dat_i        (wdat),
    .wbs_sel_i        (sel),
    .wbs_we_i         (we),
    .wbs_cyc_i        (cyc),
    .wbs_stb_i        (stb),
    .wbs_dat_o        (rdat),
    .wbs_ack_o        (ack),
    .wbs_err_o        (err),
    .wbs_rty_o        (rty)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_access(input logic w, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] q);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 4);
    chk("wb_ack", {31'b0, ack}, 32'd1);
    q = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_access(1'b1, a, d, 4'hf, q);
  endtask

  task automatic wb_read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wb_access(1'b0, a, 32'h0, 4'hf, q);
    chk(tag, q, exp);
  endtask

  task automatic pulse(input int n);
    @(negedge clk);
    irq[n] = 1'b1;
    repeat (2) @(negedge clk);
    irq[n] = 1'b0;
  endtask

  task automatic wait_do(input string tag, input logic [7:0] exp_vec);
    int n;
    n = 0;
    while (!ido && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_do"}, {31'b0, ido}, 32'd1);
    chk({tag, "_vec"}, {24'b0, ivec}, {24'b0, exp_vec});
  endtask

  task automatic ack_cpu(input string tag);
    @(negedge clk);
    idone = 1'b1;
    @(negedge clk);
    idone = 1'b0;
    chk(tag, {31'b0, ido}, 32'd0);
  endtask

  task automatic quiet(input string tag);
    repeat (8) @(negedge clk);
    chk(tag, {31'b0, ido}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_do", {31'b0, ido}, 32'd0);
    chk("rst_vec", {24'b0, ivec}, 32'd0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("err_rty", {30'b0, err, rty}, 32'd0);
    rst_n = 1'b1;
    wb_read_chk("rst_imr", 4'h0, 32'h0000_ffff);
    wb_read_chk("rst_irr", 4'h4, 32'h0);
    wb_read_chk("rst_isr", 4'h8, 32'h0);

`ifndef AO486_IRQ_LEVEL_EN
    // Single line delivery
    wb_write(4'h0, 32'h0000_fffe);
    pulse(0);
    wait_do("t1", 8'h08);
    ack_cpu("t1_drop");
    wb_read_chk("t1_isr", 4'h8, 32'h0001);
    wb_read_chk("t1_irr", 4'h4, 32'h0000);
    wb_write(4'hc, 32'h0001);
    wb_read_chk("t1_isr_eoi", 4'h8, 32'h0000);

    // Simultaneous 3 and 9: 3 first, 9 withheld until EOI of 3
    wb_write(4'h0, 32'h0);
    @(negedge clk);
    irq[3] = 1'b1; irq[9] = 1'b1;
    repeat (2) @(negedge clk);
    irq[3] = 1'b0; irq[9] = 1'b0;
    wait_do("t2a", 8'h0b);
    ack_cpu("t2a_drop");
    quiet("t2_withheld");
    wb_read_chk("t2_irr", 4'h4, 32'h0200);
    wb_write(4'h4, 32'hffff);
    wb_read_chk("t2_irr_ro", 4'h4, 32'h0200);
    wb_write(4'hc, 32'h0008);
    wait_do("t2b", 8'h71);
    ack_cpu("t2b_drop");
    wb_write(4'hc, 32'h0200);

    // Nesting: 5 in service, 2 preempts, 7 waits for both EOIs
    pulse(5);
    wait_do("t3a", 8'h0d);
    ack_cpu("t3a_drop");
    pulse(2);
    wait_do("t3b", 8'h0a);
    ack_cpu("t3b_drop");
    wb_read_chk("t3_isr", 4'h8, 32'h0024);
    pulse(7);
    quiet("t3_7_held");
    wb_write(4'hc, 32'h0004);
    quiet("t3_7_held2");
    wb_read_chk("t3_irr", 4'h4, 32'h0080);
    wb_write(4'hc, 32'h0020);
    wait_do("t3c", 8'h0f);
    ack_cpu("t3c_drop");
    wb_write(4'hc, 32'h0080);
    wb_read_chk("t3_isr_end", 4'h8, 32'h0000);

    // New edge on 4 lands in the same cycle as done for 4: set wins
    pulse(4);
    wait_do("t4a", 8'h0c);
    @(negedge clk);
    irq[4] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    idone = 1'b1;
    @(negedge clk);
    idone = 1'b0;
    irq[4] = 1'b0;
    chk("t4_drop", {31'b0, ido}, 32'd0);
    wb_read_chk("t4_irr", 4'h4, 32'h0010);
    wb_read_chk("t4_isr", 4'h8, 32'h0010);
    wb_write(4'hc, 32'h0010);
    wait_do("t4b", 8'h0c);
    ack_cpu("t4b_drop");
    wb_write(4'hc, 32'h0010);

    // Masked pending line, later unmasked; reset in REQ
    wb_write(4'h0, 32'hffff);
    pulse(1);
    quiet("t5_masked");
    wb_read_chk("t5_irr", 4'h4, 32'h0002);
    wb_write(4'h0, 32'hfffd);
    wait_do("t5", 8'h09);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_do", {31'b0, ido}, 32'd0);
    chk("t5_rst_vec", {24'b0, ivec}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_read_chk("t5_imr", 4'h0, 32'h0000_ffff);
    wb_read_chk("t5_irr_rst", 4'h4, 32'h0);

    // Byte enables: only byte 0 written
    begin
      logic [31:0] q;
      wb_access(1'b1, 4'h0, 32'h0, 4'b0001, q);
    end
    wb_read_chk("sel_imr", 4'h0, 32'h0000_ff00);
    wb_read_chk("eoi_rd", 4'hc, 32'h0);
`else
    // Level mode: line held high is re-requested after EOI; IRR follows the line
    wb_write(4'h0, 32'h0);
    @(negedge clk);
    irq[6] = 1'b1;
    wait_do("l1", 8'h0e);
    ack_cpu("l1_drop");
    wb_read_chk("l1_isr", 4'h8, 32'h0040);
    wb_read_chk("l1_irr", 4'h4, 32'h0040);
    quiet("l1_nested");
    wb_write(4'hc, 32'h0040);
    wait_do("l2", 8'h0e);
    ack_cpu("l2_drop");
    @(negedge clk);
    irq[6] = 1'b0;
    repeat (2) @(negedge clk);
    wb_read_chk("l_irr_low", 4'h4, 32'h0000);
    wb_read_chk("l_isr", 4'h8, 32'h0040);
    wb_write(4'hc, 32'h0040);
    quiet("l_idle");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
